vga_sync_counter: RTL and testbench
===================================

Name: vga_sync_counter

Overview:
- Timing generator directly upstream of the display-area check stage.
- Divides the system clock down to a pixel-rate enable.
- Produces 10-bit xcounter/ycounter, hsync/vsync and line/frame start pulses; the counters feed the display-area check and the pixel-colour logic.
- Defaults give 640x480 @ 60 Hz from a 50 MHz clk (25 MHz pixel rate).

Parameters:
- CLK_DIV, 2, clk cycles per pixel (1..16); 1 = pixel_tick permanently high after reset.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high).
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Both must be ≤ 1024; elaboration error otherwise.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- pixel_tick  output  1  one-clk enable; high once every CLK_DIV clks.
- xcounter  output  10  horizontal position, 0..H_TOTAL-1.
- ycounter  output  10  vertical position, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync, polarity per SYNC_POL.
- vsync  output  1  vertical sync, polarity per SYNC_POL.
- line_start  output  1  one-clk pulse when xcounter becomes 0.
- frame_start  output  1  one-clk pulse when (xcounter, ycounter) becomes (0,0).
- max_x  output  10  constant H_ACTIVE (for the display-area check).
- max_y  output  10  constant V_ACTIVE.

Behaviour:
- Reset: asserting reset immediately (asynchronously) forces the following. Outputs are registered, so no glitch on release.
  - Divider count = 0; pixel_tick = 0; xcounter = 0; ycounter = 0.
  - hsync = vsync = !SYNC_POL (inactive).
  - line_start = frame_start = 0.
- Reset mid-frame: same as power-up; no partial-line completion. First frame after release starts at (0,0) without a frame_start pulse.
- Divider:
  - Free-running count 0..CLK_DIV-1, wrapping to 0.
  - pixel_tick is registered, high in the clk cycle after the count reaches CLK_DIV-1.
  - First tick occurs CLK_DIV clks after reset release.
- Counters advance only in a cycle where pixel_tick = 1. Otherwise all counter, sync and pulse registers hold, and the pulses are 0.
- Horizontal: on a tick, xcounter+1. At H_TOTAL-1 it wraps to 0 and ycounter advances.
- Vertical: ycounter wraps to 0 when it is V_TOTAL-1 at an x wrap. Simultaneous x and y wrap is one update to (0,0).
- Sync decode: hsync/vsync are registered from the next-state counter values, so they are cycle-aligned with the counter outputs (zero relative latency).
  - hsync active iff H_ACTIVE+H_FP ≤ xcounter ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751 default).
  - vsync active iff V_ACTIVE+V_FP ≤ ycounter ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491 default).
  - vsync changes only on x wrap.
- Start pulses:
  - line_start = 1 for exactly one clk, in the cycle xcounter shows the new 0 after a wrap.
  - frame_start = 1 in the same cycle when ycounter also becomes 0.
- max_x/max_y: constant wires, valid during reset.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Arithmetic is 10-bit unsigned; no overflow path exists given the parameter check.

Test Plan:
- Reset hold then release (defaults) → during reset x=0, y=0, hsync=vsync=1, pixel_tick=0, max_x=640, max_y=480. First pixel_tick at 2nd clk after release; x=1 one clk after that tick.
- Tick cadence, CLK_DIV=2 then CLK_DIV=1 → pixel_tick alternates 1/0; with CLK_DIV=1 it is constantly 1 and x increments every clk.
- Horizontal sync window → hsync falls in the same cycle x=656, rises when x=752; exactly 96 ticks low per line; line_start pulse when x 799→0 with y 0→1.
- Vertical sync window → vsync low while y=490 and y=491 only (2×800 ticks). Changes coincide with x wrap cycles.
- Frame wrap → at (799,524) the next tick gives (0,0), frame_start=1 and line_start=1 for one clk. Frame period = 420000 ticks = 840000 clks.
- Async reset mid-line at (300,200) → outputs go to reset values immediately, without a clk edge. After release, counting restarts from (0,0) with no spurious frame_start.

Source files
------------

// File: rtl/vga_sync_counter.sv
// VGA timing generator: pixel-rate divider, x/y position counters,
// registered sync outputs and line/frame start pulses.
module vga_sync_counter #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] xcounter,
  output logic [9:0] ycounter,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] max_x,
  output logic [9:0] max_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_counter: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_counter: CLK_DIV out of range 1..16");
  end

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       POL      = (SYNC_POL != 0);

  logic [3:0] div_q, div_d;
  logic       tick_q, tick_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;
  logic       h_win, v_win;

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    tick_d = (div_q == DIV_LAST);
    x_d    = x_q;
    y_d    = y_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    ls_d   = 1'b0;
    fs_d   = 1'b0;
    h_win  = 1'b0;
    v_win  = 1'b0;
    if (tick_q) begin
      if (x_q == H_LAST) begin
        x_d  = 10'd0;
        ls_d = 1'b1;
        if (y_q == V_LAST) begin
          y_d  = 10'd0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
      // decode from next-state so sync lines up with the counters
      h_win = (x_d >= HS_START) && (x_d <= HS_END);
      v_win = (y_d >= VS_START) && (y_d <= VS_END);
      hs_d  = POL ? h_win : ~h_win;
      vs_d  = POL ? v_win : ~v_win;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= 4'd0;
      tick_q <= 1'b0;
      x_q    <= 10'd0;
      y_q    <= 10'd0;
      hs_q   <= ~POL;
      vs_q   <= ~POL;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign pixel_tick  = tick_q;
  assign xcounter    = x_q;
  assign ycounter    = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign max_x       = 10'(H_ACTIVE);
  assign max_y       = 10'(V_ACTIVE);

endmodule

// File: tb/tb_vga_sync_counter.sv
// Scoreboard bench: default 640x480 timing plus a tiny CLK_DIV=1,
// active-high-sync instance for vertical, frame-wrap and mid-frame reset.
module tb_vga_sync_counter;

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       tk;
    logic       ls;
    logic       fs;
    string      nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rst1;

  logic       tk0, hs0, vs0, ls0, fs0;
  logic [9:0] x0, y0, mx0, my0;
  logic       tk1, hs1, vs1, ls1, fs1;
  logic [9:0] x1, y1, mx1, my1;

  int cyc0, cyc1;
  int n_chk  = 0;
  int n_fail = 0;
  int hlow   = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  vga_sync_counter dut0 (
    .clk(clk), .reset(rst), .pixel_tick(tk0),
    .xcounter(x0), .ycounter(y0), .hsync(hs0), .vsync(vs0),
    .line_start(ls0), .frame_start(fs0), .max_x(mx0), .max_y(my0)
  );

  vga_sync_counter #(
    .CLK_DIV(1),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1)
  ) dut1 (
    .clk(clk), .reset(rst1), .pixel_tick(tk1),
    .xcounter(x1), .ycounter(y1), .hsync(hs1), .vsync(vs1),
    .line_start(ls1), .frame_start(fs1), .max_x(mx1), .max_y(my1)
  );

  always @(posedge clk or posedge rst)
    if (rst) cyc0 <= 0;
    else     cyc0 <= cyc0 + 1;

  always @(posedge clk or posedge rst1)
    if (rst1) cyc1 <= 0;
    else      cyc1 <= cyc1 + 1;

  function automatic exp_t mk(int c, int x, int y, bit hs, bit vs,
                              bit tk, bit ls, bit fs, string nm);
    exp_t e;
    e.cyc = c;
    e.x = 10'(x);
    e.y = 10'(y);
    e.hs = hs;
    e.vs = vs;
    e.tk = tk;
    e.ls = ls;
    e.fs = fs;
    e.nm = nm;
    return e;
  endfunction

  task automatic check(string nm, int c, logic [44:0] act, logic [44:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got mx=%0d my=%0d x=%0d y=%0d hs/vs/tk/ls/fs=%b want mx=%0d my=%0d x=%0d y=%0d hs/vs/tk/ls/fs=%b",
               nm, c, act[44:35], act[34:25], act[24:15], act[14:5], act[4:0],
               exp[44:35], exp[34:25], exp[24:15], exp[14:5], exp[4:0]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && hs0 == 1'b0) hlow++;
    if (!rst && cyc0 == 1600) begin
      n_chk++;
      if (hlow != 192) begin
        n_fail++;
        $display("FAIL hsync_low_clks got=%0d want=192", hlow);
      end
    end
    if (q0.size() > 0 && q0[0].cyc == cyc0) begin
      e = q0.pop_front();
      check(e.nm, cyc0,
            {mx0, my0, x0, y0, hs0, vs0, tk0, ls0, fs0},
            {10'd640, 10'd480, e.x, e.y, e.hs, e.vs, e.tk, e.ls, e.fs});
    end
    if (q1.size() > 0 && q1[0].cyc == cyc1) begin
      e = q1.pop_front();
      check(e.nm, cyc1,
            {mx1, my1, x1, y1, hs1, vs1, tk1, ls1, fs1},
            {10'd8, 10'd4, e.x, e.y, e.hs, e.vs, e.tk, e.ls, e.fs});
    end
  end

  initial begin
    rst  = 1'b1;
    rst1 = 1'b1;
    // default timing, CLK_DIV=2: position after n edges = (n-1)/2
    q0.push_back(mk(0,    0,   0, 1, 1, 0, 0, 0, "d_reset"));
    q0.push_back(mk(1,    0,   0, 1, 1, 0, 0, 0, "d_no_tick1"));
    q0.push_back(mk(2,    0,   0, 1, 1, 1, 0, 0, "d_first_tick"));
    q0.push_back(mk(3,    1,   0, 1, 1, 0, 0, 0, "d_x1"));
    q0.push_back(mk(4,    1,   0, 1, 1, 1, 0, 0, "d_tick2"));
    q0.push_back(mk(1312, 655, 0, 1, 1, 1, 0, 0, "d_x655"));
    q0.push_back(mk(1313, 656, 0, 0, 1, 0, 0, 0, "d_hs_fall"));
    q0.push_back(mk(1504, 751, 0, 0, 1, 1, 0, 0, "d_hs_last"));
    q0.push_back(mk(1505, 752, 0, 1, 1, 0, 0, 0, "d_hs_rise"));
    q0.push_back(mk(1600, 799, 0, 1, 1, 1, 0, 0, "d_x799"));
    q0.push_back(mk(1601, 0,   1, 1, 1, 0, 1, 0, "d_line_wrap"));
    q0.push_back(mk(1602, 0,   1, 1, 1, 1, 0, 0, "d_ls_one_clk"));
    q0.push_back(mk(1603, 1,   1, 1, 1, 0, 0, 0, "d_line1_x1"));
    // small timing, CLK_DIV=1: H_TOTAL=15, V_TOTAL=8, position = n-1
    q1.push_back(mk(0,   0,  0, 0, 0, 0, 0, 0, "s_reset"));
    q1.push_back(mk(1,   0,  0, 0, 0, 1, 0, 0, "s_tick"));
    q1.push_back(mk(2,   1,  0, 0, 0, 1, 0, 0, "s_x1"));
    q1.push_back(mk(3,   2,  0, 0, 0, 1, 0, 0, "s_x2"));
    q1.push_back(mk(11,  10, 0, 1, 0, 1, 0, 0, "s_hs_on"));
    q1.push_back(mk(13,  12, 0, 1, 0, 1, 0, 0, "s_hs_last"));
    q1.push_back(mk(14,  13, 0, 0, 0, 1, 0, 0, "s_hs_off"));
    q1.push_back(mk(16,  0,  1, 0, 0, 1, 1, 0, "s_line_wrap"));
    q1.push_back(mk(75,  14, 4, 0, 0, 1, 0, 0, "s_pre_vs"));
    q1.push_back(mk(76,  0,  5, 0, 1, 1, 1, 0, "s_vs_on"));
    q1.push_back(mk(105, 14, 6, 0, 1, 1, 0, 0, "s_vs_last"));
    q1.push_back(mk(106, 0,  7, 0, 0, 1, 1, 0, "s_vs_off"));
    q1.push_back(mk(120, 14, 7, 0, 0, 1, 0, 0, "s_frame_end"));
    q1.push_back(mk(121, 0,  0, 0, 0, 1, 1, 1, "s_frame_wrap"));
    q1.push_back(mk(122, 1,  0, 0, 0, 1, 0, 0, "s_after_wrap"));
    q1.push_back(mk(157, 6,  2, 0, 0, 1, 0, 0, "s_mid_frame"));
    q1.push_back(mk(0,   0,  0, 0, 0, 0, 0, 0, "s_async_reset"));
    q1.push_back(mk(1,   0,  0, 0, 0, 1, 0, 0, "s_restart"));
    q1.push_back(mk(2,   1,  0, 0, 0, 1, 0, 0, "s_restart_x1"));

    #22;
    rst  = 1'b0;
    rst1 = 1'b0;
    // lands 2ns after the edge that shows (6,2)->(7,2), before next negedge
    #1575;
    rst1 = 1'b1;
    #25;
    rst1 = 1'b0;
    #14500;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d/%0d left want=0/0",
               q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
